// File: rtl/wb32_interconnect.sv
// wb32_interconnect: two-master round-robin Wishbone B4 pipelined interconnect
// with registered address-window decode and a bus-timeout watchdog.
module wb32_interconnect #(
    parameter int                    NSLAVES       = 8,
    parameter logic [NSLAVES*32-1:0] SLAVE_BASE    = '0,
    parameter logic [NSLAVES*32-1:0] SLAVE_MASK    = '0,
    parameter int                    DEFAULT_SLAVE = NSLAVES - 1,
    parameter int                    TIMEOUT       = 255,
    parameter logic [31:0]           ERROR_DATA    = 32'hDEADBEEF
) (
    input  logic                    I_wb_clk,
    input  logic                    I_reset,
    input  logic [1:0]              I_m_cyc,
    input  logic [1:0]              I_m_stb,
    input  logic [1:0]              I_m_we,
    input  logic [59:0]             I_m_adr,
    input  logic [7:0]              I_m_sel,
    input  logic [63:0]             I_m_dat,
    output logic [31:0]             O_m_dat,
    output logic [1:0]              O_m_ack,
    output logic [1:0]              O_m_stall,
    output logic [1:0]              O_m_err,
    output logic [NSLAVES-1:0]      O_s_stb,
    output logic [29:0]             O_s_adr,
    output logic                    O_s_we,
    output logic [3:0]              O_s_sel,
    output logic [31:0]             O_s_dat,
    input  logic [NSLAVES*32-1:0]   I_s_dat,
    input  logic [NSLAVES-1:0]      I_s_ack,
    input  logic [NSLAVES-1:0]      I_s_stall,
    output logic                    O_timeout_irq,
    output logic [29:0]             O_timeout_adr
);
    localparam int          SW   = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
    localparam logic [15:0] TMAX = 16'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic        TEN  = (TIMEOUT > 0);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_t;

    state_t          r_state, w_next;
    logic            r_gnt, r_last;
    logic [SW-1:0]   r_ssel, w_dec_ssel;
    logic [15:0]     r_tcnt;
    logic [29:0]     r_timeout_adr;
    logic [1:0]      w_req, w_gnt_oh;
    logic [29:0]     w_dec_adr;
    logic            w_new_gnt, w_cyc, w_stb, w_s_stall, w_s_ack;
    logic            w_busy, w_abort, w_done, w_expire;

    assign w_req     = I_m_cyc & I_m_stb;
    assign w_new_gnt = (&w_req) ? ~r_last : w_req[1];
    assign w_dec_adr = w_new_gnt ? I_m_adr[59:30] : I_m_adr[29:0];
    assign w_gnt_oh  = r_gnt ? 2'b10 : 2'b01;
    assign w_cyc     = I_m_cyc[r_gnt];
    assign w_stb     = I_m_stb[r_gnt];
    assign w_s_stall = I_s_stall[r_ssel];
    assign w_s_ack   = I_s_ack[r_ssel];
    assign w_busy    = (r_state != IDLE);
    assign w_abort   = w_busy & ~w_cyc;
    // An ack in ISSUE only counts when it coincides with the strobe being accepted
    assign w_done    = w_cyc & w_s_ack & (((r_state == ISSUE) & w_stb & ~w_s_stall) | (r_state == WAIT_ACK));
    assign w_expire  = TEN & w_busy & w_cyc & ~w_done & (r_tcnt == TMAX);

    assign O_s_adr       = r_gnt ? I_m_adr[59:30] : I_m_adr[29:0];
    assign O_s_we        = r_gnt ? I_m_we[1] : I_m_we[0];
    assign O_s_sel       = r_gnt ? I_m_sel[7:4] : I_m_sel[3:0];
    assign O_s_dat       = r_gnt ? I_m_dat[63:32] : I_m_dat[31:0];
    assign O_timeout_adr = r_timeout_adr;

    // Descending scan so the lowest-index matching window has the final say
    always_comb begin
        w_dec_ssel = SW'(DEFAULT_SLAVE);
        for (int i = NSLAVES - 1; i >= 0; i--)
            if (({w_dec_adr, 2'b00} & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) w_dec_ssel = SW'(i);
    end

    always_ff @(posedge I_wb_clk) begin
        if (I_reset) begin
            r_state       <= IDLE;
            r_gnt         <= 1'b0;
            r_last        <= 1'b1;
            r_ssel        <= '0;
            r_tcnt        <= '0;
            r_timeout_adr <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && |w_req) begin
                r_gnt  <= w_new_gnt;
                r_ssel <= w_dec_ssel;
            end
            r_tcnt <= (r_state == IDLE) ? 16'd0 : r_tcnt + 16'd1;
            if (w_busy && w_next == IDLE) r_last <= r_gnt;
            if (w_expire) r_timeout_adr <= O_s_adr;
        end
    end

    always_comb begin
        w_next = (r_state == IDLE) ? (|w_req ? ISSUE : IDLE) :
                 (w_abort | w_done | w_expire) ? IDLE :
                 (r_state == ISSUE && w_stb && !w_s_stall) ? WAIT_ACK : r_state;
    end

    always_comb begin
        O_s_stb = '0;
        for (int i = 0; i < NSLAVES; i++)
            O_s_stb[i] = (r_state == ISSUE) && w_cyc && w_stb && (r_ssel == SW'(i));
        O_m_ack       = (w_done | w_expire) ? w_gnt_oh : 2'b00;
        O_m_err       = w_expire ? w_gnt_oh : 2'b00;
        O_m_stall     = (r_state == ISSUE) ? ~(w_gnt_oh & {2{~w_s_stall}}) : 2'b11;
        O_m_dat       = w_expire ? ERROR_DATA : w_done ? I_s_dat[32*r_ssel +: 32] : 32'd0;
        O_timeout_irq = w_expire;
    end
endmodule

// File: tb/tb_wb32_interconnect.sv
// tb_wb32_interconnect: scenario tasks plus randomized transfers checked against
// a window-table reference model and a per-slave data signature.
module tb_wb32_interconnect;
    localparam int NS = 4;
    localparam logic [NS*32-1:0] NOISE = 128'h3333_3333_2222_2222_1111_1111_0EEE_EEEE;

    logic               I_wb_clk = 1'b0;
    logic               I_reset;
    logic [1:0]         I_m_cyc, I_m_stb, I_m_we;
    logic [59:0]        I_m_adr;
    logic [7:0]         I_m_sel;
    logic [63:0]        I_m_dat;
    logic [31:0]        O_m_dat;
    logic [1:0]         O_m_ack, O_m_stall, O_m_err;
    logic [NS-1:0]      O_s_stb;
    logic [29:0]        O_s_adr;
    logic               O_s_we;
    logic [3:0]         O_s_sel;
    logic [31:0]        O_s_dat;
    logic [NS*32-1:0]   I_s_dat;
    logic [NS-1:0]      I_s_ack, I_s_stall;
    logic               O_timeout_irq;
    logic [29:0]        O_timeout_adr;

    int checks = 0;
    int failures = 0;

    logic [31:0] win_base [NS] = '{32'hFFFFF000, 32'hFFFFF000, 32'h40000000, 32'h80000000};
    logic [31:0] win_mask [NS] = '{32'hFFFFF800, 32'hFFFFF000, 32'hF0000000, 32'hF0000000};

    int x_acc_slave, x_nacc, x_ack_cyc, x_bad, x_irq_cnt, x_irq_cyc;
    logic x_ack, x_err, x_swe;
    logic [31:0] x_rd, x_sdat;
    logic [29:0] x_sadr;
    logic [3:0] x_ssel;

    wb32_interconnect #(
        .NSLAVES(NS),
        .SLAVE_BASE({32'h80000000, 32'h40000000, 32'hFFFFF000, 32'hFFFFF000}),
        .SLAVE_MASK({32'hF0000000, 32'hF0000000, 32'hFFFFF000, 32'hFFFFF800}),
        .DEFAULT_SLAVE(3),
        .TIMEOUT(16),
        .ERROR_DATA(32'hDEADBEEF)
    ) dut (
        .I_wb_clk(I_wb_clk), .I_reset(I_reset),
        .I_m_cyc(I_m_cyc), .I_m_stb(I_m_stb), .I_m_we(I_m_we), .I_m_adr(I_m_adr),
        .I_m_sel(I_m_sel), .I_m_dat(I_m_dat), .O_m_dat(O_m_dat), .O_m_ack(O_m_ack),
        .O_m_stall(O_m_stall), .O_m_err(O_m_err), .O_s_stb(O_s_stb), .O_s_adr(O_s_adr),
        .O_s_we(O_s_we), .O_s_sel(O_s_sel), .O_s_dat(O_s_dat), .I_s_dat(I_s_dat),
        .I_s_ack(I_s_ack), .I_s_stall(I_s_stall), .O_timeout_irq(O_timeout_irq),
        .O_timeout_adr(O_timeout_adr)
    );

    always #5 I_wb_clk = ~I_wb_clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Model: first window (lowest index) that matches, else the default RAM slave
    function automatic int exp_slave(input logic [31:0] badr);
        for (int i = 0; i < NS; i++)
            if ((badr & win_mask[i]) == win_base[i]) return i;
        return 3;
    endfunction

    function automatic logic [31:0] sdat(input int s, input logic [29:0] w);
        logic [1:0] s2;
        s2 = 2'(s);
        return {s2, w} ^ 32'h5A5A0000;
    endfunction

    function automatic int oh_idx(input logic [NS-1:0] v);
        int r = -1;
        for (int i = 0; i < NS; i++)
            if (v[i]) r = (r == -1) ? i : -2;
        return r;
    endfunction

    task automatic tick();
        @(posedge I_wb_clk);
        #1;
    endtask

    task automatic idle_inputs();
        I_m_cyc = '0; I_m_stb = '0; I_m_we = '0; I_m_adr = '0; I_m_sel = '0; I_m_dat = '0;
        I_s_ack = '0; I_s_stall = '0; I_s_dat = NOISE;
    endtask

    // One transfer from master m; cycle 1 is the first cycle after the request is seen in IDLE
    task automatic xfer(input int m, input logic [31:0] badr, input logic we, input logic [31:0] wd,
                        input logic [3:0] sel, input int stalls, input int lat);
        int acc_cyc = 0;
        x_nacc = 0; x_acc_slave = -1; x_ack = 0; x_err = 0; x_rd = '0; x_ack_cyc = -1;
        x_bad = 0; x_irq_cnt = 0; x_irq_cyc = -1;
        x_sadr = '0; x_sdat = '0; x_swe = 1'b0; x_ssel = '0;
        I_m_cyc = '0; I_m_stb = '0;
        I_m_cyc[m] = 1'b1; I_m_stb[m] = 1'b1; I_m_we[m] = we;
        I_m_adr[30*m +: 30] = badr[31:2]; I_m_sel[4*m +: 4] = sel; I_m_dat[32*m +: 32] = wd;
        for (int c = 1; c <= 40 && !x_ack; c++) begin
            tick();
            I_s_ack = '0;
            I_s_dat = NOISE;
            if (acc_cyc > 0) I_m_stb[m] = 1'b0;
            I_s_stall = (c <= stalls) ? '1 : '0;
            #1;
            if (O_s_stb != '0) begin
                if (acc_cyc == 0) begin
                    if (O_m_stall[m] !== (c <= stalls) || O_m_stall[1-m] !== 1'b1) x_bad++;
                    if (c > stalls) begin
                        acc_cyc = c; x_nacc++; x_acc_slave = oh_idx(O_s_stb);
                        x_sadr = O_s_adr; x_sdat = O_s_dat; x_swe = O_s_we; x_ssel = O_s_sel;
                    end
                end else x_nacc++;
            end
            if (acc_cyc > 0 && c == acc_cyc + lat && x_acc_slave >= 0) begin
                I_s_ack[x_acc_slave] = 1'b1;
                I_s_dat[32*x_acc_slave +: 32] = sdat(x_acc_slave, x_sadr);
            end
            #1;
            if (O_timeout_irq) begin x_irq_cnt++; x_irq_cyc = c; end
            if (O_m_ack[m]) begin
                x_ack = 1'b1; x_err = O_m_err[m]; x_rd = O_m_dat; x_ack_cyc = c;
            end else if (O_m_dat !== '0) x_bad++;
        end
        tick();
        idle_inputs();
        #2;
        if (O_timeout_irq) x_irq_cnt++;
    endtask

    task automatic test_reset();
        idle_inputs();
        I_reset = 1'b1;
        tick(); tick();
        I_reset = 1'b0;
        #1;
        checks++; if (O_s_stb !== '0) begin failures++; $display("FAIL reset_s_stb: got %0h expected 0", O_s_stb); end
        checks++; if (O_m_stall !== 2'b11) begin failures++; $display("FAIL reset_m_stall: got %0b expected 11", O_m_stall); end
        checks++; if (O_m_ack !== 2'b00 || O_m_err !== 2'b00) begin failures++; $display("FAIL reset_ack_err: got %0b/%0b expected 0/0", O_m_ack, O_m_err); end
        checks++; if (O_timeout_irq !== 1'b0 || O_timeout_adr !== '0) begin failures++; $display("FAIL reset_timeout: got %0b/%0h expected 0/0", O_timeout_irq, O_timeout_adr); end
        checks++; if (O_m_dat !== '0) begin failures++; $display("FAIL reset_m_dat: got %0h expected 0", O_m_dat); end
    endtask

    task automatic test_single_read();
        xfer(0, 32'hFFFFF000, 1'b0, 32'h0, 4'hF, 0, 1);
        checks++; if (x_acc_slave !== 0) begin failures++; $display("FAIL single_stb_slave: got %0d expected 0", x_acc_slave); end
        checks++; if (x_ack_cyc !== 2) begin failures++; $display("FAIL single_ack_cycle: got %0d expected 2", x_ack_cyc); end
        checks++; if (x_rd !== sdat(0, 30'h3FFFFC00)) begin failures++; $display("FAIL single_data: got %0h expected %0h", x_rd, sdat(0, 30'h3FFFFC00)); end
        checks++; if (x_err !== 1'b0 || x_nacc !== 1 || x_bad !== 0) begin failures++; $display("FAIL single_proto: got err=%0b nacc=%0d bad=%0d expected 0/1/0", x_err, x_nacc, x_bad); end
    endtask

    task automatic test_contention();
        int acks [2] = '{0, 0};
        int n = 0, g, pslave = 0;
        logic pend = 1'b0;
        logic [1:0] drop = '0, raise = '0;
        int order [$];
        idle_inputs();
        I_reset = 1'b1;
        I_m_adr = {30'h0000048D, 30'h3FFFFC00};
        I_m_sel = 8'hFF; I_m_cyc = 2'b11; I_m_stb = 2'b11;
        tick();
        I_reset = 1'b0;
        for (int c = 0; c < 100 && n < 8; c++) begin
            tick();
            I_s_ack = '0;
            I_m_stb = (I_m_stb & ~drop) | raise;
            drop = '0; raise = '0;
            if (pend) begin I_s_ack[pslave] = 1'b1; pend = 1'b0; end
            #1;
            if (O_s_stb != '0) begin
                g = (O_m_stall[0] == 1'b0) ? 0 : 1;
                order.push_back(g);
                drop[g] = 1'b1; pend = 1'b1;
                pslave = (oh_idx(O_s_stb) < 0) ? 0 : oh_idx(O_s_stb);
            end
            #1;
            for (int m = 0; m < 2; m++)
                if (O_m_ack[m]) begin acks[m]++; n++; raise[m] = 1'b1; end
        end
        tick();
        idle_inputs();
        checks++; if (n !== 8) begin failures++; $display("FAIL contention_transfers: got %0d expected 8", n); end
        checks++; if (acks[0] !== 4 || acks[1] !== 4) begin failures++; $display("FAIL contention_acks: got %0d/%0d expected 4/4", acks[0], acks[1]); end
        checks++; if (order.size() < 8) begin failures++; $display("FAIL contention_grants: got %0d expected 8", order.size()); end
        for (int i = 0; i < order.size() && i < 8; i++) begin
            checks++; if (order[i] !== i % 2) begin failures++; $display("FAIL contention_order[%0d]: got %0d expected %0d", i, order[i], i % 2); end
        end
    endtask

    task automatic test_decode();
        logic [31:0] adrs [4] = '{32'h00001234, 32'hFFFFF000, 32'hFFFFF800, 32'h40000010};
        int          exps [4] = '{3, 0, 1, 2};
        for (int i = 0; i < 4; i++) begin
            xfer(1 - (i % 2), adrs[i], 1'b0, 32'h0, 4'hF, 0, 1);
            checks++; if (x_acc_slave !== exps[i]) begin failures++; $display("FAIL decode_slave[%0h]: got %0d expected %0d", adrs[i], x_acc_slave, exps[i]); end
            checks++; if (x_rd !== sdat(exps[i], adrs[i][31:2])) begin failures++; $display("FAIL decode_data[%0h]: got %0h expected %0h", adrs[i], x_rd, sdat(exps[i], adrs[i][31:2])); end
        end
    endtask

    task automatic test_stall();
        xfer(1, 32'h40000020, 1'b1, 32'hCAFEF00D, 4'h3, 3, 1);
        checks++; if (x_nacc !== 1) begin failures++; $display("FAIL stall_accepts: got %0d expected 1", x_nacc); end
        checks++; if (x_bad !== 0) begin failures++; $display("FAIL stall_tracking: got %0d bad cycles expected 0", x_bad); end
        checks++; if (!x_ack || x_ack_cyc !== 5) begin failures++; $display("FAIL stall_ack_cycle: got %0d expected 5", x_ack_cyc); end
        checks++; if (x_sdat !== 32'hCAFEF00D || x_swe !== 1'b1 || x_ssel !== 4'h3) begin failures++; $display("FAIL stall_write_fields: got %0h/%0b/%0h expected cafef00d/1/3", x_sdat, x_swe, x_ssel); end
    endtask

    task automatic test_timeout();
        xfer(0, 32'hFFFFFC00, 1'b0, 32'h0, 4'hF, 0, 1000);
        checks++; if (!x_ack || x_ack_cyc !== 16) begin failures++; $display("FAIL timeout_cycle: got %0d expected 16", x_ack_cyc); end
        checks++; if (x_err !== 1'b1 || x_rd !== 32'hDEADBEEF) begin failures++; $display("FAIL timeout_err_data: got %0b/%0h expected 1/deadbeef", x_err, x_rd); end
        checks++; if (x_irq_cnt !== 1 || x_irq_cyc !== 16) begin failures++; $display("FAIL timeout_irq: got cnt=%0d cyc=%0d expected 1/16", x_irq_cnt, x_irq_cyc); end
        checks++; if (O_timeout_adr !== 30'h3FFFFF00) begin failures++; $display("FAIL timeout_adr: got %0h expected 3fffff00", O_timeout_adr); end
        xfer(0, 32'hFFFFFC00, 1'b0, 32'h0, 4'hF, 0, 15);
        checks++; if (x_ack_cyc !== 16 || x_err !== 1'b0 || x_irq_cnt !== 0) begin failures++; $display("FAIL timeout_ack_wins: got cyc=%0d err=%0b irq=%0d expected 16/0/0", x_ack_cyc, x_err, x_irq_cnt); end
        checks++; if (x_rd !== sdat(1, 30'h3FFFFF00)) begin failures++; $display("FAIL timeout_ack_wins_data: got %0h expected %0h", x_rd, sdat(1, 30'h3FFFFF00)); end
        xfer(1, 32'h80000100, 1'b0, 32'h0, 4'hF, 100, 0);
        checks++; if (x_ack_cyc !== 16 || x_err !== 1'b1 || x_nacc !== 0) begin failures++; $display("FAIL timeout_in_issue: got cyc=%0d err=%0b nacc=%0d expected 16/1/0", x_ack_cyc, x_err, x_nacc); end
        checks++; if (O_timeout_adr !== 30'h20000040) begin failures++; $display("FAIL timeout_adr_update: got %0h expected 20000040", O_timeout_adr); end
    endtask

    task automatic test_abort();
        idle_inputs();
        I_m_cyc[0] = 1'b1; I_m_stb[0] = 1'b1; I_m_adr[29:0] = 30'h3FFFFC00;
        tick();
        #1;
        checks++; if (O_s_stb !== 4'b0001) begin failures++; $display("FAIL abort_issue_stb: got %0b expected 0001", O_s_stb); end
        tick();
        I_m_stb[0] = 1'b0; I_m_cyc[0] = 1'b0;
        #2;
        checks++; if (O_m_ack !== 2'b00) begin failures++; $display("FAIL abort_no_ack: got %0b expected 00", O_m_ack); end
        tick();
        I_s_ack[0] = 1'b1;
        #2;
        checks++; if (O_m_stall !== 2'b11 || O_s_stb !== '0) begin failures++; $display("FAIL abort_idle: got stall=%0b stb=%0b expected 11/0", O_m_stall, O_s_stb); end
        checks++; if (O_m_ack !== 2'b00 || O_m_dat !== '0) begin failures++; $display("FAIL abort_stray_ack: got %0b/%0h expected 00/0", O_m_ack, O_m_dat); end
        tick();
        I_s_ack = '0;
        xfer(0, 32'hFFFFF004, 1'b0, 32'h0, 4'hF, 0, 2);
        checks++; if (x_ack_cyc !== 3 || x_rd !== sdat(0, 30'h3FFFFC01)) begin failures++; $display("FAIL abort_recover: got cyc=%0d dat=%0h expected 3/%0h", x_ack_cyc, x_rd, sdat(0, 30'h3FFFFC01)); end
    endtask

    task automatic test_reset_mid_issue();
        idle_inputs();
        I_s_stall = '1;
        I_m_cyc[1] = 1'b1; I_m_stb[1] = 1'b1; I_m_adr[59:30] = 30'h10000004;
        tick();
        #1;
        checks++; if (O_s_stb !== 4'b0100) begin failures++; $display("FAIL rst_mid_issue_stb: got %0b expected 0100", O_s_stb); end
        I_reset = 1'b1;
        tick();
        #1;
        checks++; if (O_s_stb !== '0 || O_m_stall !== 2'b11) begin failures++; $display("FAIL rst_mid_outputs: got stb=%0b stall=%0b expected 0/11", O_s_stb, O_m_stall); end
        checks++; if (O_m_ack !== '0 || O_m_err !== '0 || O_timeout_irq !== 1'b0 || O_timeout_adr !== '0) begin failures++; $display("FAIL rst_mid_status: got %0b/%0b/%0b/%0h expected 0/0/0/0", O_m_ack, O_m_err, O_timeout_irq, O_timeout_adr); end
        I_reset = 1'b0;
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        logic [31:0] badr, wd;
        logic [3:0] sel;
        logic we;
        int m, st, lat, es;
        for (int i = 0; i < 16; i++) begin
            m = int'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: badr = 32'hFFFFF000 | ($urandom & 32'h7FC);
                1: badr = 32'hFFFFF800 | ($urandom & 32'h7FC);
                2: badr = 32'h40000000 | ($urandom & 32'h0FFFFFFC);
                3: badr = 32'h80000000 | ($urandom & 32'h0FFFFFFC);
                default: badr = $urandom & 32'h0FFFFFFC;
            endcase
            wd = $urandom; sel = 4'($urandom); we = 1'($urandom);
            st = int'($urandom_range(0, 2)); lat = int'($urandom_range(0, 3));
            es = exp_slave(badr);
            xfer(m, badr, we, wd, sel, st, lat);
            checks++; if (x_acc_slave !== es) begin failures++; $display("FAIL rand%0d_slave: got %0d expected %0d", i, x_acc_slave, es); end
            checks++; if (x_ack_cyc !== st + 1 + lat || x_err !== 1'b0) begin failures++; $display("FAIL rand%0d_ack: got cyc=%0d err=%0b expected %0d/0", i, x_ack_cyc, x_err, st + 1 + lat); end
            checks++; if (x_rd !== sdat(es, badr[31:2])) begin failures++; $display("FAIL rand%0d_data: got %0h expected %0h", i, x_rd, sdat(es, badr[31:2])); end
            checks++; if (x_sadr !== badr[31:2] || x_sdat !== wd || x_swe !== we || x_ssel !== sel) begin failures++; $display("FAIL rand%0d_fields: got %0h/%0h/%0b/%0h expected %0h/%0h/%0b/%0h", i, x_sadr, x_sdat, x_swe, x_ssel, badr[31:2], wd, we, sel); end
            checks++; if (x_nacc !== 1 || x_bad !== 0) begin failures++; $display("FAIL rand%0d_proto: got nacc=%0d bad=%0d expected 1/0", i, x_nacc, x_bad); end
        end
    endtask

    initial begin
        I_reset = 1'b0;
        idle_inputs();
        test_reset();
        test_single_read();
        test_contention();
        test_decode();
        test_stall();
        test_timeout();
        test_abort();
        test_reset_mid_issue();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
